// File: rtl/tpc_noc_ingress.sv
// Purpose    : multi-channel NoC RX front end; per-channel FIFOs, round-robin pop, routes beats to IMEM or SRAM.
// Latency    : beat accepted at edge E is popped at edge E+1; imem_we / sram_valid high in the cycle after E+1.
// Backpressure: rx_ready[c] = FIFO c not full; SRAM stall holds the request and blocks only data heads.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-high reset
//   rx_valid/rx_ready/rx_is_instr  per-channel handshake and beat type
//   rx_addr, rx_data               per-channel address/data, channel c at [c*W +: W]
//   imem_we/imem_addr/imem_wdata   one-cycle instruction memory write
//   sram_valid/sram_ready          data write request with valid/ready handshake
//   sram_addr/sram_wdata           data write address/word, held while stalled
//   busy                           any FIFO non-empty or an SRAM request outstanding
//   err_range, err_clr             sticky out-of-range instruction drop flag and its clear
//   instr_count, data_count        wrapping counts of instruction writes / accepted data writes

// Generic synchronous FIFO with registered pointers and unregistered read port.
// Latency: push visible at dout the cycle after the push edge when empty.
// Backpressure: push ignored while full, pop ignored while empty.
module tpc_noc_ingress_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   // One extra pointer bit distinguishes full from empty.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign dout  = mem[rd_ptr[AW-1:0]];

   // Storage carries no reset; only the pointers define validity.
   always_ff @(posedge clk) begin
      if (push && !full) begin
         mem[wr_ptr[AW-1:0]] <= din;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push && !full) begin
            wr_ptr <= wr_ptr + (AW+1)'(1);
         end
         if (pop && !empty) begin
            rd_ptr <= rd_ptr + (AW+1)'(1);
         end
      end
   end
endmodule

module tpc_noc_ingress #(
   parameter int DATA_W     = 256,
   parameter int ADDR_W     = 20,
   parameter int INSTR_W    = 128,
   parameter int IMEM_DEPTH = 256,
   parameter int NUM_CH     = 2,
   parameter int FIFO_DEPTH = 4,
   parameter int CNT_W      = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_CH-1:0]             rx_valid,
   output logic [NUM_CH-1:0]             rx_ready,
   input  logic [NUM_CH-1:0]             rx_is_instr,
   input  logic [NUM_CH*ADDR_W-1:0]      rx_addr,
   input  logic [NUM_CH*DATA_W-1:0]      rx_data,
   output logic                          imem_we,
   output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
   output logic [INSTR_W-1:0]            imem_wdata,
   output logic                          sram_valid,
   input  logic                          sram_ready,
   output logic [ADDR_W-1:0]             sram_addr,
   output logic [DATA_W-1:0]             sram_wdata,
   output logic                          busy,
   output logic                          err_range,
   input  logic                          err_clr,
   output logic [CNT_W-1:0]              instr_count,
   output logic [CNT_W-1:0]              data_count
);
   localparam int IA_W  = $clog2(IMEM_DEPTH);
   localparam int ENT_W = 1 + ADDR_W + DATA_W;
   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   // Limit is one bit wider than the address so IMEM_DEPTH = 2^ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] IMEM_LIM = (ADDR_W+1)'(IMEM_DEPTH);

   logic [ENT_W-1:0]  fifo_din  [NUM_CH];
   logic [ENT_W-1:0]  fifo_dout [NUM_CH];
   logic [NUM_CH-1:0] fifo_full;
   logic [NUM_CH-1:0] fifo_empty;
   logic [NUM_CH-1:0] fifo_push;
   logic [NUM_CH-1:0] fifo_pop;
   logic [NUM_CH-1:0] eligible;

   // Holds rx_ready low while rst is high and for the edge that releases it.
   logic              ready_en;

   logic [PTR_W-1:0]  rr_ptr;
   logic              grant_vld;
   logic [PTR_W-1:0]  grant_idx;
   int                rr_idx;

   logic [ENT_W-1:0]  sel_ent;
   logic              sel_instr;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic              addr_ok;
   logic              err_set;

   assign rx_ready  = {NUM_CH{ready_en}} & ~fifo_full;
   assign fifo_push = rx_valid & rx_ready;

   for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      assign fifo_din[c] = {rx_is_instr[c], rx_addr[c*ADDR_W +: ADDR_W], rx_data[c*DATA_W +: DATA_W]};

      tpc_noc_ingress_fifo #(
         .W     (ENT_W),
         .DEPTH (FIFO_DEPTH)
      ) u_fifo (
         .clk   (clk),
         .rst   (rst),
         .push  (fifo_push[c]),
         .pop   (fifo_pop[c]),
         .din   (fifo_din[c]),
         .dout  (fifo_dout[c]),
         .full  (fifo_full[c]),
         .empty (fifo_empty[c])
      );

      // A data head may only issue into an empty output register or one being drained this edge;
      // instruction heads never wait, so SRAM stalls cannot starve them.
      assign eligible[c] = !fifo_empty[c] && (fifo_dout[c][ENT_W-1] || !sram_valid || sram_ready);
   end

   // Round-robin search starting at rr_ptr, first eligible channel wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_idx = '0;
      rr_idx    = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         rr_idx = int'(rr_ptr) + i;
         if (rr_idx >= NUM_CH) begin
            rr_idx = rr_idx - NUM_CH;
         end
         if (!grant_vld && eligible[rr_idx]) begin
            grant_vld = 1'b1;
            grant_idx = PTR_W'(rr_idx);
         end
      end
   end

   always_comb begin
      sel_ent  = '0;
      fifo_pop = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         if (grant_vld && (grant_idx == PTR_W'(c))) begin
            sel_ent     = fifo_dout[c];
            fifo_pop[c] = 1'b1;
         end
      end
   end

   assign sel_instr = sel_ent[ENT_W-1];
   assign sel_addr  = sel_ent[DATA_W +: ADDR_W];
   assign sel_data  = sel_ent[DATA_W-1:0];
   assign addr_ok   = ({1'b0, sel_addr} < IMEM_LIM);
   assign err_set   = grant_vld && sel_instr && !addr_ok;

   assign busy = (|(~fifo_empty)) || sram_valid;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ready_en <= 1'b0;
         rr_ptr   <= '0;
      end else begin
         ready_en <= 1'b1;
         if (grant_vld) begin
            if (grant_idx == PTR_W'(NUM_CH-1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= grant_idx + PTR_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         imem_we     <= 1'b0;
         imem_addr   <= '0;
         imem_wdata  <= '0;
         sram_valid  <= 1'b0;
         sram_addr   <= '0;
         sram_wdata  <= '0;
         err_range   <= 1'b0;
         instr_count <= '0;
         data_count  <= '0;
      end else begin
         imem_we <= 1'b0;

         if (imem_we) begin
            instr_count <= instr_count + CNT_W'(1);
         end

         // Completion first; a data pop on the same edge below re-asserts sram_valid.
         if (sram_valid && sram_ready) begin
            data_count <= data_count + CNT_W'(1);
            sram_valid <= 1'b0;
         end

         if (grant_vld) begin
            if (sel_instr) begin
               if (addr_ok) begin
                  imem_we    <= 1'b1;
                  imem_addr  <= sel_addr[IA_W-1:0];
                  imem_wdata <= sel_data[INSTR_W-1:0];
               end
            end else begin
               sram_valid <= 1'b1;
               sram_addr  <= sel_addr;
               sram_wdata <= sel_data;
            end
         end

         if (err_set) begin
            err_range <= 1'b1;
         end else if (err_clr) begin
            err_range <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_tpc_noc_ingress.sv
// Directed bench for tpc_noc_ingress: reset, instruction load, SRAM backpressure,
// round-robin fairness, range errors and mixed blocking with mid-stream reset.
module tb_tpc_noc_ingress;
   localparam int DATA_W = 256;
   localparam int ADDR_W = 20;
   localparam int NUM_CH = 2;

   logic                     clk;
   logic                     rst;
   logic [NUM_CH-1:0]        rx_valid;
   logic [NUM_CH-1:0]        rx_ready;
   logic [NUM_CH-1:0]        rx_is_instr;
   logic [NUM_CH*ADDR_W-1:0] rx_addr;
   logic [NUM_CH*DATA_W-1:0] rx_data;
   logic                     imem_we;
   logic [7:0]               imem_addr;
   logic [127:0]             imem_wdata;
   logic                     sram_valid;
   logic                     sram_ready;
   logic [ADDR_W-1:0]        sram_addr;
   logic [DATA_W-1:0]        sram_wdata;
   logic                     busy;
   logic                     err_range;
   logic                     err_clr;
   logic [15:0]              instr_count;
   logic [15:0]              data_count;

   int checks = 0;
   int errors = 0;

   logic [7:0]        imem_log [$];
   logic [ADDR_W-1:0] sram_log [$];

   tpc_noc_ingress dut (
      .clk         (clk),
      .rst         (rst),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .rx_is_instr (rx_is_instr),
      .rx_addr     (rx_addr),
      .rx_data     (rx_data),
      .imem_we     (imem_we),
      .imem_addr   (imem_addr),
      .imem_wdata  (imem_wdata),
      .sram_valid  (sram_valid),
      .sram_ready  (sram_ready),
      .sram_addr   (sram_addr),
      .sram_wdata  (sram_wdata),
      .busy        (busy),
      .err_range   (err_range),
      .err_clr     (err_clr),
      .instr_count (instr_count),
      .data_count  (data_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Inputs change 1ns after posedge; the log samples at negedge what the next posedge commits.
   always @(negedge clk) begin
      if (!rst) begin
         if (imem_we) imem_log.push_back(imem_addr);
         if (sram_valid && sram_ready) sram_log.push_back(sram_addr);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input int ch, input logic instr, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data);
      rx_valid[ch]                    = 1'b1;
      rx_is_instr[ch]                 = instr;
      rx_addr[ch*ADDR_W +: ADDR_W]    = addr;
      rx_data[ch*DATA_W +: DATA_W]    = data;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      rx_valid = '0; rx_is_instr = '0; rx_addr = '0; rx_data = '0;
      sram_ready = 1'b1; err_clr = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (rx_ready !== 2'b00) begin errors++; $display("FAIL reset_rdy_in_rst: got %b exp 00", rx_ready); end
      rst = 1'b0;
      step();
      checks++; if (rx_ready !== 2'b11) begin errors++; $display("FAIL reset_rdy: got %b exp 11", rx_ready); end
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL reset_imem_we: got %b exp 0", imem_we); end
      checks++; if (sram_valid !== 1'b0) begin errors++; $display("FAIL reset_sram_valid: got %b exp 0", sram_valid); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
      checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL reset_err: got %b exp 0", err_range); end
      checks++; if (instr_count !== 16'd0) begin errors++; $display("FAIL reset_icnt: got %0d exp 0", instr_count); end
      checks++; if (data_count !== 16'd0) begin errors++; $display("FAIL reset_dcnt: got %0d exp 0", data_count); end
   endtask

   task automatic test_halt_load();
      logic [127:0] exp_w;
      logic [DATA_W-1:0] beat;
      exp_w = {8'h07, 8'h00, 112'd0};
      beat  = {128'hFFFF_EEEE_DDDD_CCCC_BBBB_AAAA_9999_8888, exp_w};
      imem_log.delete();
      drive(0, 1'b1, 20'd0, beat);
      step();                      // accepted at this edge
      rx_valid = '0;
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL halt_we_early: got %b exp 0", imem_we); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL halt_busy: got %b exp 1", busy); end
      step();                      // pop edge
      checks++; if (imem_we !== 1'b1) begin errors++; $display("FAIL halt_we: got %b exp 1", imem_we); end
      checks++; if (imem_addr !== 8'd0) begin errors++; $display("FAIL halt_addr: got %0d exp 0", imem_addr); end
      checks++; if (imem_wdata !== exp_w) begin errors++; $display("FAIL halt_wdata: got %h exp %h", imem_wdata, exp_w); end
      step();
      checks++; if (imem_we !== 1'b0) begin errors++; $display("FAIL halt_we_len: got %b exp 0", imem_we); end
      checks++; if (instr_count !== 16'd1) begin errors++; $display("FAIL halt_icnt: got %0d exp 1", instr_count); end
   endtask

   task automatic test_backpressure();
      sram_ready = 1'b0;
      sram_log.delete();
      for (int i = 0; i < 5; i++) begin
         drive(1, 1'b0, 20'h100 + 20'(i), DATA_W'(32'hD000 + i));
         step();
      end
      checks++; if (rx_ready[1] !== 1'b0) begin errors++; $display("FAIL bp_full: got %b exp 0", rx_ready[1]); end
      checks++; if (sram_valid !== 1'b1 || sram_addr !== 20'h100) begin
         errors++; $display("FAIL bp_head: got valid=%b addr=%h exp valid=1 addr=100", sram_valid, sram_addr); end
      checks++; if (sram_wdata !== DATA_W'(32'hD000)) begin errors++; $display("FAIL bp_wdata: got %h exp d000", sram_wdata); end
      drive(1, 1'b0, 20'h1FF, DATA_W'(32'hBAD));   // must be refused while full
      step();
      rx_valid = '0;
      checks++; if (rx_ready[1] !== 1'b0 || sram_addr !== 20'h100) begin
         errors++; $display("FAIL bp_hold: got rdy=%b addr=%h exp rdy=0 addr=100", rx_ready[1], sram_addr); end
      sram_ready = 1'b1;
      repeat (10) step();
      checks++; if (sram_log.size() !== 5) begin errors++; $display("FAIL bp_count: got %0d writes exp 5", sram_log.size()); end
      for (int i = 0; i < 5 && i < sram_log.size(); i++) begin
         checks++; if (sram_log[i] !== 20'h100 + 20'(i)) begin
            errors++; $display("FAIL bp_order[%0d]: got %h exp %h", i, sram_log[i], 20'h100 + 20'(i)); end
      end
      checks++; if (data_count !== 16'd5) begin errors++; $display("FAIL bp_dcnt: got %0d exp 5", data_count); end
      checks++; if (sram_valid !== 1'b0 || busy !== 1'b0) begin
         errors++; $display("FAIL bp_drain: got valid=%b busy=%b exp 0 0", sram_valid, busy); end
   endtask

   task automatic test_fairness();
      logic [7:0] exp_seq [8];
      exp_seq = '{8'd0, 8'd8, 8'd1, 8'd9, 8'd2, 8'd10, 8'd3, 8'd11};
      imem_log.delete();
      for (int i = 0; i < 4; i++) begin
         drive(0, 1'b1, 20'(i), DATA_W'(i));
         drive(1, 1'b1, 20'(8 + i), DATA_W'(8 + i));
         step();
      end
      rx_valid = '0;
      repeat (12) step();
      checks++; if (imem_log.size() !== 8) begin errors++; $display("FAIL rr_count: got %0d exp 8", imem_log.size()); end
      for (int i = 0; i < 8 && i < imem_log.size(); i++) begin
         checks++; if (imem_log[i] !== exp_seq[i]) begin
            errors++; $display("FAIL rr_seq[%0d]: got %0d exp %0d", i, imem_log[i], exp_seq[i]); end
      end
      checks++; if (instr_count !== 16'd9) begin errors++; $display("FAIL rr_icnt: got %0d exp 9", instr_count); end
   endtask

   task automatic test_range_error();
      imem_log.delete();
      drive(0, 1'b1, 20'd300, DATA_W'(1));
      step();
      rx_valid = '0;
      repeat (4) step();
      checks++; if (imem_log.size() !== 0) begin errors++; $display("FAIL rng_we: got %0d writes exp 0", imem_log.size()); end
      checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL rng_err: got %b exp 1", err_range); end
      checks++; if (instr_count !== 16'd9) begin errors++; $display("FAIL rng_icnt: got %0d exp 9", instr_count); end
      err_clr = 1'b1;
      step();
      err_clr = 1'b0;
      checks++; if (err_range !== 1'b0) begin errors++; $display("FAIL rng_clr: got %b exp 0", err_range); end
      drive(0, 1'b1, 20'd256, DATA_W'(2));      // first illegal address
      step();                                    // accepted
      rx_valid = '0;
      err_clr = 1'b1;
      step();                                    // pop edge coincides with clear
      err_clr = 1'b0;
      checks++; if (err_range !== 1'b1) begin errors++; $display("FAIL rng_set_wins: got %b exp 1", err_range); end
      drive(0, 1'b1, 20'd255, DATA_W'(3));      // last legal address
      step();
      rx_valid = '0;
      repeat (4) step();
      checks++; if (imem_log.size() !== 1) begin errors++; $display("FAIL rng_edge_cnt: got %0d exp 1", imem_log.size()); end
      else begin
         checks++; if (imem_log[0] !== 8'd255) begin errors++; $display("FAIL rng_edge_addr: got %0d exp 255", imem_log[0]); end
      end
      checks++; if (instr_count !== 16'd10) begin errors++; $display("FAIL rng_icnt2: got %0d exp 10", instr_count); end
   endtask

   task automatic test_mixed_and_reset();
      sram_ready = 1'b0;
      imem_log.delete();
      sram_log.delete();
      drive(0, 1'b0, 20'h200, DATA_W'(7));
      step();
      drive(0, 1'b0, 20'h201, DATA_W'(8));
      step();
      rx_valid = '0;
      drive(1, 1'b1, 20'd5, DATA_W'(9));
      step();
      rx_valid = '0;
      repeat (5) step();
      checks++; if (imem_log.size() !== 1) begin errors++; $display("FAIL mix_instr_cnt: got %0d exp 1", imem_log.size()); end
      else begin
         checks++; if (imem_log[0] !== 8'd5) begin errors++; $display("FAIL mix_instr_addr: got %0d exp 5", imem_log[0]); end
      end
      checks++; if (sram_valid !== 1'b1 || sram_addr !== 20'h200 || busy !== 1'b1) begin
         errors++; $display("FAIL mix_stall: got valid=%b addr=%h busy=%b exp 1 200 1", sram_valid, sram_addr, busy); end
      #2;
      rst = 1'b1;                 // asynchronous, between edges
      #1;
      checks++; if (sram_valid !== 1'b0 || busy !== 1'b0 || rx_ready !== 2'b00) begin
         errors++; $display("FAIL arst_now: got valid=%b busy=%b rdy=%b exp 0 0 00", sram_valid, busy, rx_ready); end
      checks++; if (instr_count !== 16'd0 || data_count !== 16'd0) begin
         errors++; $display("FAIL arst_cnt: got %0d %0d exp 0 0", instr_count, data_count); end
      repeat (2) step();
      rst = 1'b0;
      sram_ready = 1'b1;
      imem_log.delete();
      sram_log.delete();
      repeat (8) step();
      checks++; if (imem_log.size() !== 0 || sram_log.size() !== 0) begin
         errors++; $display("FAIL arst_writes: got imem=%0d sram=%0d exp 0 0", imem_log.size(), sram_log.size()); end
      checks++; if (rx_ready !== 2'b11 || busy !== 1'b0 || data_count !== 16'd0) begin
         errors++; $display("FAIL arst_idle: got rdy=%b busy=%b dcnt=%0d exp 11 0 0", rx_ready, busy, data_count); end
   endtask

   initial begin
      test_reset();
      test_halt_load();
      test_backpressure();
      test_fairness();
      test_range_error();
      test_mixed_and_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
